wall_map_buffer: RTL and testbench

Double-buffered wall-map store between the software PIO wall-write port (addr/data/write-enable level exports) and the renderer. Software writes a new map into the back bank while the renderer reads the front bank through `READ_PORTS` independent registered read ports. A software commit swaps the banks only at the next frame sync, so the renderer never shows a half-written map. Adds parametrised width, depth and read-port count, plus a hardware clear sweep, over the plain wall PIO path.

---
 rtl/wall_map_buffer.sv | 224 ++++++++++++++++++++++
 tb/tb_wall_map_buffer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wall_map_buffer.sv
// ============================================================================
// Module   : wall_map_buffer
// Purpose  : Double-buffered wall-map store. Software writes the back bank
//            through level-style PIO exports while the renderer reads the
//            front bank through READ_PORTS registered read ports. A commit
//            swaps the banks only at the next frame sync. Both banks are
//            zeroed by a hardware sweep after reset, and the back bank can be
//            zeroed on request.
// Ports    : Clk_i          system clock
//            Reset_i        asynchronous active-high reset
//            wr_addr_i      write address (PIO level)
//            wr_data_i      write data (PIO level)
//            wr_we_i        write strobe level, acts on rising edge
//            commit_i       swap request level, acts on rising edge
//            clear_i        clear-back-bank request level, acts on rising edge
//            frame_sync_i   one-cycle pulse at start of vertical blank
//            rd_addr_i      packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//            rd_data_o      packed registered read data from the front bank
//            front_sel_o    index of the bank currently displayed
//            busy_o         high while sweeping or waiting for a swap
//            write_count_o  accepted writes since last swap, saturating
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wall_map_buffer #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int READ_PORTS = 2
) (
    input  logic                         Clk_i,
    input  logic                         Reset_i,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    input  logic                         wr_we_i,
    input  logic                         commit_i,
    input  logic                         clear_i,
    input  logic                         frame_sync_i,
    input  logic [READ_PORTS*ADDR_W-1:0] rd_addr_i,
    output logic [READ_PORTS*DATA_W-1:0] rd_data_o,
    output logic                         front_sel_o,
    output logic                         busy_o,
    output logic [ADDR_W:0]              write_count_o
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_INIT      = 2'd0,
        S_IDLE      = 2'd1,
        S_CLEAR     = 2'd2,
        S_SWAP_PEND = 2'd3
    } state_t;

    state_t              state_q;
    logic                we_q;
    logic                commit_q;
    logic                clear_q;
    logic                pend_q;
    logic                front_sel_q;
    logic [ADDR_W-1:0]   sweep_q;
    logic [ADDR_W:0]     write_count_q;

    logic [DATA_W-1:0]   bank0_q [DEPTH];
    logic [DATA_W-1:0]   bank1_q [DEPTH];
    logic [DATA_W-1:0]   rd_q    [READ_PORTS];

    logic                w_we_evt;
    logic                w_commit_evt;
    logic                w_clear_evt;
    logic                w_sweep_last;
    logic                w_wr0;
    logic                w_wr1;
    logic [ADDR_W-1:0]   w_maddr;
    logic [DATA_W-1:0]   w_mdata;

    // Edge detectors reset to 1 so a level already high at reset release
    // does not count as an event.
    assign w_we_evt     = wr_we_i  & ~we_q;
    assign w_commit_evt = commit_i & ~commit_q;
    assign w_clear_evt  = clear_i  & ~clear_q;
    assign w_sweep_last = (sweep_q == {ADDR_W{1'b1}});

    // ------------------------------------------------------------------------
    // Control FSM and status registers
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q       <= S_INIT;
            we_q          <= 1'b1;
            commit_q      <= 1'b1;
            clear_q       <= 1'b1;
            pend_q        <= 1'b0;
            front_sel_q   <= 1'b0;
            sweep_q       <= '0;
            write_count_q <= '0;
        end else begin
            we_q     <= wr_we_i;
            commit_q <= commit_i;
            clear_q  <= clear_i;

            case (state_q)
                S_INIT: begin
                    // Sweep wraps back to 0 on the last address.
                    sweep_q <= sweep_q + 1'b1;
                    if (w_sweep_last) begin
                        state_q <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (w_we_evt && (write_count_q != {(ADDR_W+1){1'b1}})) begin
                        write_count_q <= write_count_q + 1'b1;
                    end
                    if (w_clear_evt) begin
                        // Clear takes priority; a simultaneous commit is kept.
                        sweep_q <= '0;
                        pend_q  <= w_commit_evt;
                        state_q <= S_CLEAR;
                    end else if (w_commit_evt) begin
                        state_q <= S_SWAP_PEND;
                    end
                end

                S_CLEAR: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (w_commit_evt) begin
                        pend_q <= 1'b1;
                    end
                    if (w_sweep_last) begin
                        state_q <= (pend_q || w_commit_evt) ? S_SWAP_PEND : S_IDLE;
                        pend_q  <= 1'b0;
                    end
                end

                S_SWAP_PEND: begin
                    if (frame_sync_i) begin
                        front_sel_q   <= ~front_sel_q;
                        write_count_q <= '0;
                        state_q       <= S_IDLE;
                    end else if (w_we_evt &&
                                 (write_count_q != {(ADDR_W+1){1'b1}})) begin
                        write_count_q <= write_count_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Bank write selection. The back bank is the one not selected by
    // front_sel; INIT is the only time both banks are written together.
    // ------------------------------------------------------------------------
    always_comb begin
        w_wr0   = 1'b0;
        w_wr1   = 1'b0;
        w_maddr = sweep_q;
        w_mdata = '0;
        case (state_q)
            S_INIT: begin
                w_wr0 = 1'b1;
                w_wr1 = 1'b1;
            end
            S_CLEAR: begin
                w_wr0 = front_sel_q;
                w_wr1 = ~front_sel_q;
            end
            S_IDLE, S_SWAP_PEND: begin
                if (w_we_evt) begin
                    w_maddr = wr_addr_i;
                    w_mdata = wr_data_i;
                    w_wr0   = front_sel_q;
                    w_wr1   = ~front_sel_q;
                end
            end
            default: begin
                w_wr0 = 1'b0;
                w_wr1 = 1'b0;
            end
        endcase
    end

    // Storage carries no reset; contents are established by the INIT sweep.
    always_ff @(posedge Clk_i) begin
        if (w_wr0) begin
            bank0_q[w_maddr] <= w_mdata;
        end
        if (w_wr1) begin
            bank1_q[w_maddr] <= w_mdata;
        end
    end

    // ------------------------------------------------------------------------
    // Registered read ports. Reads use the front_sel value before any swap in
    // the same cycle, so a read in the swap cycle still returns the old front.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            for (int i = 0; i < READ_PORTS; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < READ_PORTS; i++) begin
                rd_q[i] <= front_sel_q ? bank1_q[rd_addr_i[i*ADDR_W +: ADDR_W]]
                                       : bank0_q[rd_addr_i[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    for (genvar g = 0; g < READ_PORTS; g++) begin : g_rd_pack
        assign rd_data_o[g*DATA_W +: DATA_W] = rd_q[g];
    end

    assign front_sel_o   = front_sel_q;
    assign busy_o        = (state_q != S_IDLE);
    assign write_count_o = write_count_q;

endmodule

`default_nettype wire

// File: tb/tb_wall_map_buffer.sv
// ============================================================================
// Module   : tb_wall_map_buffer
// Purpose  : Directed self-checking bench for wall_map_buffer. Read
//            expectations are queued when addresses are driven and compared
//            when the registered read data appears one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wall_map_buffer;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int RP = 2;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             wr_we;
    logic             commit;
    logic             clear;
    logic             frame_sync;
    logic [RP*AW-1:0] rd_addr;
    logic [RP*DW-1:0] rd_data;
    logic             front_sel;
    logic             busy;
    logic [AW:0]      write_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned   port;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t sb[$];

    always #5 Clk = ~Clk;

    wall_map_buffer #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .READ_PORTS (RP)
    ) dut (
        .Clk_i         (Clk),
        .Reset_i       (Reset),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .wr_we_i       (wr_we),
        .commit_i      (commit),
        .clear_i       (clear),
        .frame_sync_i  (frame_sync),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .front_sel_o   (front_sel),
        .busy_o        (busy),
        .write_count_o (write_count)
    );

    // Inputs change and outputs are sampled 1 time unit after the clock edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one address per port, queue expectations, compare after 1 cycle.
    task automatic rd_cycle(input string tag,
                            input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        rd_exp_t e;
        rd_addr = {a1, a0};
        sb.push_back('{port: 0, data: e0});
        sb.push_back('{port: 1, data: e1});
        step();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(tag, 32'(rd_data[e.port*DW +: DW]), 32'(e.data));
        end
    endtask

    // Front bank expected all zero: port 0 ascending, port 1 descending.
    task automatic scan_zero(input string tag);
        for (int a = 0; a < (1 << AW); a++) begin
            rd_cycle(tag, AW'(a), AW'((1 << AW) - 1 - a), '0, '0);
        end
    endtask

    // Number of cycles until busy drops, bounded.
    task automatic measure_busy(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (busy && n < 1000);
        check(tag, 32'(n), 32'(exp_n));
    endtask

    task automatic wr_pulse(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_addr = a;
        wr_data = d;
        wr_we   = 1'b1;
        step();
        wr_we   = 1'b0;
    endtask

    initial begin
        int busy_drops;

        Reset      = 1'b1;
        wr_addr    = '0;
        wr_data    = '0;
        wr_we      = 1'b0;
        commit     = 1'b0;
        clear      = 1'b0;
        frame_sync = 1'b0;
        rd_addr    = '0;
        repeat (3) step();

        // Reset state
        check("reset_rd_data", 32'(rd_data), 32'h0);
        check("reset_front_sel", 32'(front_sel), 32'h0);
        check("reset_busy", 32'(busy), 32'h1);
        check("reset_write_count", 32'(write_count), 32'h0);

        // INIT sweep length and zeroed contents
        Reset = 1'b0;
        measure_busy("init_busy_cycles", 256);
        check("init_front_sel", 32'(front_sel), 32'h0);
        scan_zero("init_zero");

        // Write to back, invisible until swap
        wr_pulse(8'h12, 8'hA5);
        check("wc_after_write", 32'(write_count), 32'h1);
        rd_cycle("front_unchanged", 8'h12, 8'h12, 8'h00, 8'h00);
        commit = 1'b1;
        step();
        commit = 1'b0;
        check("swap_pend_busy", 32'(busy), 32'h1);
        repeat (3) step();
        check("no_swap_before_sync", 32'(front_sel), 32'h0);
        frame_sync = 1'b1;
        rd_cycle("read_in_swap_cycle", 8'h12, 8'h12, 8'h00, 8'h00);
        frame_sync = 1'b0;
        check("swap_front_sel", 32'(front_sel), 32'h1);
        check("swap_write_count", 32'(write_count), 32'h0);
        check("swap_busy", 32'(busy), 32'h0);
        rd_cycle("new_front_a5", 8'h00, 8'h12, 8'h00, 8'hA5);

        // Held write strobe gives a single write
        wr_addr = 8'h03;
        wr_data = 8'h33;
        wr_we   = 1'b1;
        repeat (5) step();
        wr_we   = 1'b0;
        step();
        check("wc_held_we_once", 32'(write_count), 32'h1);

        // Write strobe held high through reset gives no write
        wr_we = 1'b1;
        Reset = 1'b1;
        repeat (2) step();
        check("reset2_front_sel", 32'(front_sel), 32'h0);
        check("reset2_write_count", 32'(write_count), 32'h0);
        Reset = 1'b0;
        measure_busy("reinit_busy_cycles", 256);
        repeat (3) step();
        check("wc_we_held_through_reset", 32'(write_count), 32'h0);
        wr_we = 1'b0;
        step();

        // Clear with a later commit, frame_sync during sweep ignored
        wr_pulse(8'h55, 8'h99);
        check("wc_before_clear", 32'(write_count), 32'h1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        busy_drops = 0;
        for (int k = 1; k <= 300; k++) begin
            if (k == 10) commit = 1'b1;
            if (k == 11) commit = 1'b0;
            if (k == 20) begin
                wr_addr = 8'h66;
                wr_data = 8'h11;
                wr_we   = 1'b1;
            end
            if (k == 21) wr_we = 1'b0;
            if (k == 50) frame_sync = 1'b1;
            if (k == 51) frame_sync = 1'b0;
            step();
            if (!busy) busy_drops++;
        end
        check("clear_commit_busy_drops", 32'(busy_drops), 32'h0);
        check("no_swap_during_clear", 32'(front_sel), 32'h0);
        check("wc_clear_drops_write", 32'(write_count), 32'h1);
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        check("clear_swap_front_sel", 32'(front_sel), 32'h1);
        check("clear_swap_write_count", 32'(write_count), 32'h0);
        check("clear_swap_busy", 32'(busy), 32'h0);
        scan_zero("cleared_front_zero");

        // Plain clear timing
        clear = 1'b1;
        step();
        clear = 1'b0;
        measure_busy("clear_cycles", 256);

        // Writes in SWAP_PEND, one coinciding with frame_sync
        commit = 1'b1;
        step();
        commit = 1'b0;
        step();
        wr_pulse(8'h41, 8'h22);
        step();
        wr_addr    = 8'h40;
        wr_data    = 8'h7E;
        wr_we      = 1'b1;
        frame_sync = 1'b1;
        step();
        wr_we      = 1'b0;
        frame_sync = 1'b0;
        check("sync_write_front_sel", 32'(front_sel), 32'h0);
        check("sync_write_count", 32'(write_count), 32'h0);
        check("sync_write_busy", 32'(busy), 32'h0);
        rd_cycle("front_40_41", 8'h40, 8'h41, 8'h7E, 8'h22);

        // Reset in the middle of a clear sweep
        wr_pulse(8'h10, 8'h5A);
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (100) step();
        Reset = 1'b1;
        step();
        check("rd_data_in_reset", 32'(rd_data), 32'h0);
        check("midclear_reset_front_sel", 32'(front_sel), 32'h0);
        check("midclear_reset_busy", 32'(busy), 32'h1);
        step();
        Reset = 1'b0;
        measure_busy("midclear_reinit_cycles", 256);
        scan_zero("bank0_rezeroed");
        commit = 1'b1;
        step();
        commit = 1'b0;
        step();
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        check("final_swap_front_sel", 32'(front_sel), 32'h1);
        scan_zero("bank1_rezeroed");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
